memoria_resposta: RTL and testbench
===================================

# memoria_resposta

Word-addressed data/instruction memory responder for the multicycle MIPS datapath. Answers read and write requests issued by the processor's control FSM, with a programmable fixed read latency and a one-cycle `Pronto` completion pulse. The control side can either count wait states or wait on `Pronto`. Also checks alignment and exposes its FSM state for debug.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, 16..4096.
- `READ_LAT`, 2: cycles from request acceptance to read completion; 1..15.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `Req`  in  1  request strobe, sampled only in state OCIOSO.
- `EscreveMem`  in  1  with `Req`: 1 = write, 0 = read.
- `Endereco`  in  32  byte address.
- `DadoEntrada`  in  32  write data.
- `DadoSaida`  out  32  last read data (registered).
- `Pronto`  out  1  one-cycle completion pulse.
- `ErroAlinh`  out  1  qualifies `Pronto`: request rejected, misaligned.
- `Ocupado`  out  1  high whenever state is not OCIOSO.
- `Estado`  out  2  FSM state: OCIOSO=0, LEITURA=1, RESPOSTA=2.

## Operation
- Word index = `Endereco[$clog2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS`.
- Acceptance: `Req`=1 at a rising edge while in OCIOSO. On acceptance, latch address, data and the write flag. While not in OCIOSO, `Req` is ignored and not queued.
- Misaligned request (`Endereco[1:0]`≠0), read or write:
  - No array access.
  - Go to RESPOSTA, where `Pronto`=1 and `ErroAlinh`=1.
  - `DadoSaida` is unchanged.
- Aligned write:
  - Array word is written at the accepting edge.
  - Go to RESPOSTA, where `Pronto`=1 and `ErroAlinh`=0.
  - `DadoSaida` is unchanged.
- Aligned read:
  - If `READ_LAT`=1, go directly to RESPOSTA.
  - Otherwise go to LEITURA. Load the wait counter (width `$clog2(READ_LAT)`) with `READ_LAT-2` and decrement each cycle. When it is 0, go to RESPOSTA.
  - The array is read at the edge entering RESPOSTA, using the latched address; `DadoSaida` is loaded at that edge.
- RESPOSTA always lasts exactly one cycle, then OCIOSO. `Req` in RESPOSTA is ignored.
- `Pronto` and `ErroAlinh` are registered outputs: high only in RESPOSTA.
- Illegal `Estado` encoding (3) goes to OCIOSO on the next edge with no side effects.

## Timing
- Reset asserted (`reset`=0), asynchronously:
  - state OCIOSO, counter 0.
  - `DadoSaida`=0, `Pronto`=0, `ErroAlinh`=0, `Ocupado`=0, `Estado`=0.
  - Array contents are not cleared.
- Reset release: the first edge with `reset`=1 may accept a request.
- Request sampled at the edge ending cycle c:
  - Write or misaligned request: `Pronto` in cycle c+1.
  - Aligned read: `Pronto` and valid `DadoSaida` in cycle c+`READ_LAT`.
  - Next request can be accepted at the edge ending the `Pronto` cycle + 1, i.e. `Req` held in OCIOSO.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per `READ_LAT`+1 cycles.
- `Ocupado` is high from cycle c+1 through the `Pronto` cycle inclusive.
- Reset during LEITURA: the read is abandoned and `Pronto` never fires. A reset during a write has no effect on an already-committed array word.
- Back-to-back write then read of the same address returns the new data; there is no hazard because the write commits before the read is accepted.

## Test plan
- Reset mid-read: accept a read, drop `reset` in LEITURA -> all outputs 0 immediately, `Estado`=0, no `Pronto` after release; array contents intact when read back.
- Write then read, `READ_LAT`=2: write 0xDEADBEEF to 0x10, `Pronto` in c+1; read 0x10 -> `Pronto`=1 in c+2, `DadoSaida`=0xDEADBEEF, `Estado` sequence 1,2,0.
- `READ_LAT`=1 build: read 0x0 after writing 0x12345678 -> `Pronto` in next cycle, `Estado` goes 0→2→0 with no LEITURA.
- Misaligned: read 0x13 with `DadoSaida`=0xDEADBEEF -> `Pronto`=`ErroAlinh`=1 in c+1, `DadoSaida` still 0xDEADBEEF. Misaligned write to 0x22 -> array word 8 unchanged.
- Busy/wrap: `Req` held high continuously during a read -> second access accepted only after RESPOSTA. With `DEPTH_WORDS`=256, a write to 0x400 aliases 0x000 and reads back equal.

Source files
------------

// File: rtl/memoria_resposta.sv
// Word-addressed memory responder for the multicycle MIPS datapath; one request outstanding at a time.
// Latency: write/misaligned = 1 cycle, aligned read = READ_LAT cycles; Req is ignored (not queued) while Ocupado.
module memoria_resposta #(
    parameter int DEPTH_WORDS = 256,
    parameter int READ_LAT    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Req,
    input  logic        EscreveMem,
    input  logic [31:0] Endereco,
    input  logic [31:0] DadoEntrada,
    output logic [31:0] DadoSaida,
    output logic        Pronto,
    output logic        ErroAlinh,
    output logic        Ocupado,
    output logic [1:0]  Estado
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        LEITURA  = 2'd1,
        RESPOSTA = 2'd2,
        ILEGAL   = 2'd3
    } estado_t;

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [31:0]      dout_q;
    logic             pronto_q;
    logic             erro_q, erro_d;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [AW-1:0]    idx_in;
    logic [AW-1:0]    rd_idx;
    logic             misal;
    logic             wr_en;
    logic             rd_fire;
    logic             unused_addr_hi;

    // Upper address bits are deliberately dropped so accesses wrap modulo the array size.
    assign idx_in         = Endereco[AW+1:2];
    assign misal          = (Endereco[1:0] != 2'b00);
    assign unused_addr_hi = ^Endereco[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        erro_d  = 1'b0;
        wr_en   = 1'b0;
        rd_fire = 1'b0;
        rd_idx  = addr_q;
        case (state_q)
            OCIOSO: begin
                if (Req) begin
                    addr_d = idx_in;
                    if (misal) begin
                        erro_d  = 1'b1;
                        state_d = RESPOSTA;
                    end else if (EscreveMem) begin
                        wr_en   = 1'b1;
                        state_d = RESPOSTA;
                    end else if (READ_LAT == 1) begin
                        rd_fire = 1'b1;
                        rd_idx  = idx_in;
                        state_d = RESPOSTA;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = LEITURA;
                    end
                end
            end
            LEITURA: begin
                if (cnt_q == '0) begin
                    rd_fire = 1'b1;
                    state_d = RESPOSTA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESPOSTA: state_d = OCIOSO;
            default:  state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= OCIOSO;
            cnt_q    <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            pronto_q <= (state_d == RESPOSTA);
            erro_q   <= erro_d;
            if (rd_fire) begin
                dout_q <= mem[rd_idx];
            end
        end
    end

    // The array has no reset, so writes are suppressed explicitly while reset is held.
    always_ff @(posedge clock) begin
        if (wr_en && reset) begin
            mem[idx_in] <= DadoEntrada;
        end
    end

    assign DadoSaida = dout_q;
    assign Pronto    = pronto_q;
    assign ErroAlinh = erro_q;
    assign Ocupado   = (state_q != OCIOSO);
    assign Estado    = state_q;

endmodule

// File: tb/tb_memoria_resposta.sv
// Directed bench for memoria_resposta: READ_LAT=2 instance for most vectors, a READ_LAT=1 instance for the short path.
module tb_memoria_resposta;

    logic        clock;
    logic        reset;
    logic        req, we;
    logic [31:0] addr, din;
    logic [31:0] dout;
    logic        pronto, erro, ocup;
    logic [1:0]  est;

    logic        req1, we1;
    logic [31:0] addr1, din1;
    logic [31:0] dout1;
    logic        pronto1, erro1, ocup1;
    logic [1:0]  est1;

    int checks   = 0;
    int failures = 0;

    memoria_resposta #(.DEPTH_WORDS(256), .READ_LAT(2)) dut (
        .clock(clock), .reset(reset), .Req(req), .EscreveMem(we),
        .Endereco(addr), .DadoEntrada(din), .DadoSaida(dout),
        .Pronto(pronto), .ErroAlinh(erro), .Ocupado(ocup), .Estado(est)
    );

    memoria_resposta #(.DEPTH_WORDS(256), .READ_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .Req(req1), .EscreveMem(we1),
        .Endereco(addr1), .DadoEntrada(din1), .DadoSaida(dout1),
        .Pronto(pronto1), .ErroAlinh(erro1), .Ocupado(ocup1), .Estado(est1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        req  = 1'b1;
        we   = w;
        addr = a;
        din  = d;
        step();
        req  = 1'b0;
    endtask

    initial begin
        int npronto;
        reset = 1'b0;
        req = 0; we = 0; addr = 0; din = 0;
        req1 = 0; we1 = 0; addr1 = 0; din1 = 0;
        step();
        step();
        check("rst_dout",   dout,   32'h0);
        check("rst_pronto", pronto, 32'h0);
        check("rst_erro",   erro,   32'h0);
        check("rst_ocup",   ocup,   32'h0);
        check("rst_estado", est,    32'h0);
        reset = 1'b1;

        // Aligned write, Pronto in c+1
        issue(1'b1, 32'h10, 32'hDEADBEEF);
        check("wr_pronto", pronto, 32'h1);
        check("wr_erro",   erro,   32'h0);
        check("wr_estado", est,    32'h2);
        check("wr_ocup",   ocup,   32'h1);
        step();
        check("wr_idle_pronto", pronto, 32'h0);
        check("wr_idle_estado", est,    32'h0);

        // Aligned read, READ_LAT=2: states 1,2,0
        issue(1'b0, 32'h10, 32'h0);
        check("rd_c1_estado", est,    32'h1);
        check("rd_c1_pronto", pronto, 32'h0);
        check("rd_c1_ocup",   ocup,   32'h1);
        step();
        check("rd_c2_estado", est,    32'h2);
        check("rd_c2_pronto", pronto, 32'h1);
        check("rd_c2_dout",   dout,   32'hDEADBEEF);
        step();
        check("rd_c3_estado", est,    32'h0);
        check("rd_c3_pronto", pronto, 32'h0);

        // Misaligned read
        issue(1'b0, 32'h13, 32'h0);
        check("mis_rd_pronto", pronto, 32'h1);
        check("mis_rd_erro",   erro,   32'h1);
        check("mis_rd_estado", est,    32'h2);
        check("mis_rd_dout",   dout,   32'hDEADBEEF);
        step();
        check("mis_rd_erro_clr", erro, 32'h0);

        // Misaligned write must not touch word 8
        issue(1'b1, 32'h20, 32'hA5A50008);
        step();
        issue(1'b1, 32'h22, 32'hFFFFFFFF);
        check("mis_wr_erro",   erro,   32'h1);
        check("mis_wr_pronto", pronto, 32'h1);
        check("mis_wr_dout",   dout,   32'hDEADBEEF);
        step();
        issue(1'b0, 32'h20, 32'h0);
        step();
        check("word8_intact", dout, 32'hA5A50008);
        step();

        // Req held high: second access only after RESPOSTA
        req = 1'b1; we = 1'b0; addr = 32'h10;
        step();
        check("busy_c1_estado", est, 32'h1);
        addr = 32'h20;
        step();
        check("busy_c2_estado", est,  32'h2);
        check("busy_c2_dout",   dout, 32'hDEADBEEF);
        step();
        check("busy_c3_estado", est,  32'h0);
        check("busy_c3_ocup",   ocup, 32'h0);
        step();
        check("busy_c4_estado", est, 32'h1);
        step();
        check("busy_c5_estado", est,  32'h2);
        check("busy_c5_dout",   dout, 32'hA5A50008);
        req = 1'b0;
        step();

        // Address wrap: 0x400 aliases 0x000
        issue(1'b1, 32'h400, 32'h0BADF00D);
        step();
        issue(1'b0, 32'h000, 32'h0);
        step();
        check("wrap_dout", dout, 32'h0BADF00D);
        step();

        // Reset during LEITURA
        issue(1'b0, 32'h10, 32'h0);
        check("rstmid_estado_pre", est, 32'h1);
        reset = 1'b0;
        #1;
        check("rstmid_dout",   dout,   32'h0);
        check("rstmid_pronto", pronto, 32'h0);
        check("rstmid_ocup",   ocup,   32'h0);
        check("rstmid_estado", est,    32'h0);
        step();
        reset = 1'b1;
        npronto = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pronto) npronto++;
        end
        check("rstmid_no_pronto", npronto, 32'h0);
        issue(1'b0, 32'h0, 32'h0);
        step();
        check("rstmid_array_intact", dout, 32'h0BADF00D);
        step();

        // READ_LAT=1 instance: 0 -> 2 -> 0, no LEITURA
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h0; din1 = 32'h12345678;
        step();
        req1 = 1'b0;
        check("l1_wr_pronto", pronto1, 32'h1);
        step();
        check("l1_idle_estado", est1, 32'h0);
        req1 = 1'b1; we1 = 1'b0;
        step();
        req1 = 1'b0;
        check("l1_rd_estado", est1,    32'h2);
        check("l1_rd_pronto", pronto1, 32'h1);
        check("l1_rd_erro",   erro1,   32'h0);
        check("l1_rd_dout",   dout1,   32'h12345678);
        step();
        check("l1_end_estado", est1,  32'h0);
        check("l1_end_ocup",   ocup1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
